// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner: key count, index map of the
// non-digit keys, the per-key debounce FSM state type and a small helper used
// by the digit arbitration.
// -----------------------------------------------------------------------------
package button_pkg;

  localparam int NUM_BTN     = 12;
  localparam int NUM_DIGITS  = 10;
  localparam int CONFIRM_IDX = 10;
  localparam int SHUFFLE_IDX = 11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // True when two or more bits are set: clearing the lowest set bit leaves
  // something behind only if another bit was set.
  function automatic logic more_than_one(input logic [NUM_DIGITS-1:0] v);
    return |(v & (v - NUM_DIGITS'(1)));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One key: 2-flop synchronizer, IDLE/PRESS_WAIT/HELD/RELEASE_WAIT debounce FSM
// with a saturating debounce counter, and an optional hold timer for stuck-key
// detection (enabled by defining BTN_STUCK_DETECT_EN).
//
// Ports
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_raw    : unsynchronized, bouncy key level
//   o_pulse  : one-cycle pulse in the cycle the FSM enters HELD
//   o_stuck  : level, key held for STUCK_CYCLES cycles (0 when feature off)
// -----------------------------------------------------------------------------
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STUCK_CYCLES    = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_stuck
);

  // The WAIT states are entered on the first differing sample, then need
  // DEBOUNCE_CYCLES further samples, so the counter compares against D-1.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES out of range 1..65535");
  end
  if (STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_stuck
    $error("btn_debounce: STUCK_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]  r_sync;
  logic        w_level;
  btn_state_e  r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_pulse, w_pulse_nxt;

  assign w_level = r_sync[1];

  // Synchronizer stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_raw};
  end

  // Debounce FSM stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Counter is zero on every state change and in the stable states.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 16'd0;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_level) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!w_level) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt = ST_HELD;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = sat_inc16(r_cnt);
        end
      end
      ST_HELD: begin
        if (!w_level) w_state_nxt = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        // Bounce back to HELD without a pulse: still the same press.
        if (w_level) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = sat_inc16(r_cnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_pulse = r_pulse;

`ifdef BTN_STUCK_DETECT_EN
  localparam logic [31:0] ST_LAST = 32'(STUCK_CYCLES - 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_hold;
  logic        r_stuck;

  // Hold timer stage: counts cycles spent in HELD/RELEASE_WAIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold  <= 32'd0;
      r_stuck <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_hold  <= 32'd0;
      r_stuck <= 1'b0;
    end else if (r_state == ST_HELD || r_state == ST_RELEASE_WAIT) begin
      r_hold <= sat_inc32(r_hold);
      if (r_hold == ST_LAST) r_stuck <= 1'b1;
    end
  end

  assign o_stuck = r_stuck;
`else
  assign o_stuck = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions 10 digit keys plus confirm and shuffle into clean one-cycle press
// pulses. Each key runs its own btn_debounce; this level only arbitrates the
// digits so that at most one digit pulse reaches the lock per cycle.
// Optional stuck-key detection: define BTN_STUCK_DETECT_EN.
//
// Ports
//   clk            : system clock, rising edge
//   rstn           : asynchronous active-low reset
//   digit_raw_i    : [9:0] raw digit keys
//   confirm_raw_i  : raw confirm key
//   shuffle_raw_i  : raw shuffle key
//   digit_buttons  : [9:0] one-cycle digit press, at most one bit high
//   confirm_button : one-cycle confirm press
//   shuffle_button : one-cycle shuffle press
//   multi_press_o  : one-cycle pulse when >=2 digits accepted together
//   stuck_o        : [11:0] stuck level per key (digits, confirm, shuffle)
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STUCK_CYCLES    = 1000000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_DIGITS-1:0] digit_raw_i,
  input  logic                  confirm_raw_i,
  input  logic                  shuffle_raw_i,
  output logic [NUM_DIGITS-1:0] digit_buttons,
  output logic                  confirm_button,
  output logic                  shuffle_button,
  output logic                  multi_press_o,
  output logic [NUM_BTN-1:0]    stuck_o
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_pulse;
  logic [NUM_BTN-1:0] w_stuck;
  logic               w_multi;

  assign w_raw = {shuffle_raw_i, confirm_raw_i, digit_raw_i};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_deb (
      .i_clk  (clk),
      .i_rst_n(rstn),
      .i_raw  (w_raw[g]),
      .o_pulse(w_pulse[g]),
      .o_stuck(w_stuck[g])
    );
  end

  // Simultaneous digit accepts are ambiguous: suppress them all and flag it.
  // The keys themselves still sit in HELD inside their debouncers.
  assign w_multi        = more_than_one(w_pulse[NUM_DIGITS-1:0]);
  assign digit_buttons  = w_multi ? '0 : w_pulse[NUM_DIGITS-1:0];
  assign multi_press_o  = w_multi;
  assign confirm_button = w_pulse[CONFIRM_IDX];
  assign shuffle_button = w_pulse[SHUFFLE_IDX];
  assign stuck_o        = w_stuck;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios plus random key activity, compared every cycle against a
// reference model: a key's accepted level flips once the synchronized input
// has disagreed with it for DEBOUNCE_CYCLES+1 consecutive samples; a 0->1 flip
// is a press pulse; stuck is raised after STUCK_CYCLES cycles at level 1.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D = 16;
  localparam int S = 100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] raw;
  logic [9:0]  digit_buttons;
  logic        confirm_button, shuffle_button, multi_press_o;
  logic [11:0] stuck_o;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] m_d1, m_d2, m_acc, m_pulse, m_stuck;
  int          m_run [12];
  int          m_held[12];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .digit_raw_i   (raw[9:0]),
    .confirm_raw_i (raw[10]),
    .shuffle_raw_i (raw[11]),
    .digit_buttons (digit_buttons),
    .confirm_button(confirm_button),
    .shuffle_button(shuffle_button),
    .multi_press_o (multi_press_o),
    .stuck_o       (stuck_o)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_d1 = '0; m_d2 = '0; m_acc = '0; m_pulse = '0; m_stuck = '0;
    for (int i = 0; i < 12; i++) begin
      m_run[i]  = 0;
      m_held[i] = 0;
    end
  endtask

  // Advance the model by one rising edge using the raw levels seen at it.
  task automatic model_edge();
    logic [11:0] s;
    logic        was, flip;
    if (!rstn) begin
      model_clear();
      return;
    end
    s    = m_d2;          // level after the two synchronizer flops
    m_d2 = m_d1;
    m_d1 = raw;
    m_pulse = '0;
    for (int i = 0; i < 12; i++) begin
      was  = m_acc[i];
      flip = 1'b0;
      if (s[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          flip      = 1'b1;
          m_acc[i]  = ~m_acc[i];
          m_run[i]  = 0;
          m_pulse[i] = ~was;
        end
      end else begin
        m_run[i] = 0;
      end
`ifdef BTN_STUCK_DETECT_EN
      if (flip && was) begin
        m_held[i]  = 0;
        m_stuck[i] = 1'b0;
      end else if (was) begin
        if (m_held[i] < S) m_held[i]++;
        if (m_held[i] >= S) m_stuck[i] = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_outputs();
    logic        e_multi;
    logic [9:0]  e_dig;
    e_multi = ($countones(m_pulse[9:0]) > 1);
    e_dig   = e_multi ? 10'd0 : m_pulse[9:0];
    chk("digit_buttons", {2'b00, digit_buttons}, {2'b00, e_dig});
    chk("multi_press",   {11'd0, multi_press_o}, {11'd0, e_multi});
    chk("confirm",       {11'd0, confirm_button}, {11'd0, m_pulse[10]});
    chk("shuffle",       {11'd0, shuffle_button}, {11'd0, m_pulse[11]});
    chk("stuck",         stuck_o, m_stuck);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    raw  = '0;
    rstn = 1'b0;
    model_clear();
    repeat (3) step();
    rstn = 1'b1;
    repeat (3) step();

    // Clean press of digit 3: single pulse 18 cycles after the rise is sampled
    raw[3] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("d3_pulse_time", {2'b00, digit_buttons}, (i == D + 3) ? 12'h008 : 12'h000);
    end
    raw[3] = 1'b0;
    repeat (40) step();

    // Digit 5 bouncing every 4 cycles never qualifies
    for (int i = 0; i < 100; i++) begin
      raw[5] = (i < 60) ? (((i / 4) % 2) == 0) : 1'b0;
      step();
      chk("d5_bounce_quiet", {2'b00, digit_buttons}, 12'h000);
    end

    // Digits 1 and 7 together: suppressed, multi-press flagged once
    raw[1] = 1'b1; raw[7] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("d17_multi", {11'd0, multi_press_o}, (i == D + 3) ? 12'h001 : 12'h000);
      chk("d17_digits", {2'b00, digit_buttons}, 12'h000);
    end
    raw[1] = 1'b0; raw[7] = 1'b0;
    repeat (40) step();

    // Confirm and shuffle together: both pulse in the same cycle
    raw[10] = 1'b1; raw[11] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("conf_shuf_pair", {10'd0, shuffle_button, confirm_button},
          (i == D + 3) ? 12'h003 : 12'h000);
    end
    raw[10] = 1'b0; raw[11] = 1'b0;
    repeat (40) step();

    // Digit 2 held across a reset: pending press dropped, new press after release
    raw[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("d2_pre_reset", {2'b00, digit_buttons}, 12'h000);
    end
    rstn = 1'b0;
    model_clear();
    #1;
    chk("reset_outputs", {digit_buttons, confirm_button, shuffle_button}, 12'h000);
    repeat (2) step();
    rstn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("d2_post_reset", {2'b00, digit_buttons}, (i == D + 3) ? 12'h004 : 12'h000);
    end
    raw[2] = 1'b0;
    repeat (40) step();

`ifdef BTN_STUCK_DETECT_EN
    // Shuffle held long enough to be flagged stuck, cleared after release
    raw[11] = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      chk("stuck_rise", {11'd0, stuck_o[11]}, (i >= D + 3 + S) ? 12'h001 : 12'h000);
    end
    raw[11] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("stuck_clear", {11'd0, stuck_o[11]}, (i < D + 3) ? 12'h001 : 12'h000);
    end
`endif

    // Random key activity with one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 12; i++)
        if ($urandom_range(0, 24) == 0) raw[i] = ~raw[i];
      if (n == 700) begin
        rstn = 1'b0;
        model_clear();
      end
      if (n == 703) rstn = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized cycles needed to accept a level change (legal 1..65535).
REQ-002 SHALL have parameter STUCK_CYCLES, default 1000000, meaning held cycles after a press before the stuck flag is raised (legal > DEBOUNCE_CYCLES, < 2^32).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port digit_raw_i  input  10  unsynchronized, bouncy digit keys; bit i is key i.
REQ-006 SHALL have port confirm_raw_i  input  1  unsynchronized confirm key.
REQ-007 SHALL have port shuffle_raw_i  input  1  unsynchronized shuffle key.
REQ-008 SHALL have port digit_buttons  output  10  one-cycle press pulses feeding the lock's digit input; at most one bit high.
REQ-009 SHALL have port confirm_button  output  1  one-cycle confirm press pulse.
REQ-010 SHALL have port shuffle_button  output  1  one-cycle shuffle press pulse.
REQ-011 SHALL have port multi_press_o  output  1  one-cycle pulse when two or more digit presses are accepted in the same cycle.
REQ-012 SHALL have port stuck_o  output  12  level flag per key, bits [9:0] digits, bit 10 confirm, bit 11 shuffle.

Function
REQ-013 SHALL pass each of the 12 raw inputs through a 2-flop synchronizer before any other logic.
REQ-014 SHALL run an independent per-key FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-015 IDLE->PRESS_WAIT on synchronized high; PRESS_WAIT->IDLE on any low sample; PRESS_WAIT->HELD after DEBOUNCE_CYCLES consecutive high samples.
REQ-016 HELD->RELEASE_WAIT on synchronized low; RELEASE_WAIT->HELD on any high sample; RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive low samples.
REQ-017 SHALL emit the key's accepted-press pulse exactly in the cycle the FSM enters HELD, once per press, with no repeat while held.
REQ-018 A raw level change stable from edge k SHALL produce its pulse in cycle k+2+DEBOUNCE_CYCLES.
REQ-019 A glitch (high or low) shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no state change beyond the WAIT state.
REQ-020 If exactly one digit is accepted in a cycle, SHALL drive that bit of digit_buttons.
REQ-021 If two or more digits are accepted in the same cycle, SHALL drive digit_buttons to 0 and pulse multi_press_o; those keys still enter HELD.
REQ-022 A digit accepted while another digit is HELD SHALL pulse normally.
REQ-023 Confirm and shuffle SHALL be independent of the digits and of each other; simultaneous pulses are allowed.
REQ-024 Debounce counters SHALL saturate, never wrap, and clear on every state change.

Reset
REQ-025 On rstn low, SHALL asynchronously force synchronizers to 0, all FSMs to IDLE, all counters to 0, and all outputs to 0.
REQ-026 A key held across reset release SHALL be treated as a new press: one pulse at DEBOUNCE_CYCLES+2 cycles after release.
REQ-027 Reset mid-debounce or mid-HELD SHALL discard the pending press with no pulse.

Configuration
REQ-028 With BTN_STUCK_DETECT_EN defined, SHALL set stuck_o[i] once key i has been HELD/RELEASE_WAIT for STUCK_CYCLES cycles, and clear it on entering IDLE.
REQ-029 Without BTN_STUCK_DETECT_EN, stuck_o SHALL be constant 0, no hold counters SHALL be synthesized, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package button_pkg SHALL hold NUM_BTN=12, the index constants CONFIRM_IDX=10 and SHUFFLE_IDX=11, and the FSM state enum.
REQ-031 Per-key synchronizer, FSM and counters SHALL live in sub-module btn_debounce, instantiated 12 times; the top level holds only the digit arbitration.

Verification
REQ-032 Digit 3 high 40 cycles clean, DEBOUNCE_CYCLES=16 -> digit_buttons=0x008 for exactly one cycle, 18 cycles after rise.
REQ-033 Digit 5 toggling every 4 cycles for 60 cycles, then low -> no pulse on any output.
REQ-034 Digits 1 and 7 rising on the same edge -> digit_buttons stays 0, multi_press_o pulses once.
REQ-035 Confirm and shuffle rising together -> both pulse in the same cycle.
REQ-036 Digit 2 held, rstn pulsed low at cycle 10 and released -> no pulse before reset, one pulse 18 cycles after release.
REQ-037 Macro on, STUCK_CYCLES=100, shuffle held 200 cycles -> stuck_o[11] rises at cycle 100 after accept, clears 16+2 cycles after release.
